// File: rtl/pixel_wb_sequencer.sv
// pixel_wb_sequencer: Wishbone initiator that runs one full MixPix pixel
// acquisition (program timers and data input, pulse start, settle, read
// DATA_OUT, pulse done) against the pixel slave register block.
module pixel_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [9:0]  loc_max_clk_i,
  input  logic [9:0]  adj_max_clk_i,
  input  logic        loc_timer_m_i,
  input  logic        adj_timer_m_i,
  input  logic        data_in_i,
  input  logic [15:0] settle_cycles_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] result_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_GAP, ST_WAIT, ST_FIN} state_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  off;
    logic [31:0] dat;
  } txn_t;

  localparam logic [7:0] TO_LAST   = 8'(ACK_TIMEOUT - 1);
  localparam logic [3:0] TXN_READ  = 4'd7;   // DATA_OUT read, preceded by settle
  localparam logic [3:0] TXN_COUNT = 4'd10;

  // Fixed transaction list: index -> register offset, direction, write data.
  function automatic txn_t txn_lookup(input logic [3:0] idx, input logic [9:0] loc,
                                      input logic [9:0] adj, input logic lm,
                                      input logic am, input logic din);
    txn_t t;
    t = '{we: 1'b1, off: 5'd4, dat: 32'd0};
    case (idx)
      4'd0:    t = '{we: 1'b1, off: 5'd20, dat: {22'd0, loc}};
      4'd1:    t = '{we: 1'b1, off: 5'd24, dat: {22'd0, adj}};
      4'd2:    t = '{we: 1'b1, off: 5'd8,  dat: {31'd0, lm}};
      4'd3:    t = '{we: 1'b1, off: 5'd12, dat: {31'd0, am}};
      4'd4:    t = '{we: 1'b1, off: 5'd16, dat: {31'd0, din}};
      4'd5:    t = '{we: 1'b1, off: 5'd0,  dat: 32'd1};
      4'd6:    t = '{we: 1'b1, off: 5'd0,  dat: 32'd0};
      4'd7:    t = '{we: 1'b0, off: 5'd28, dat: 32'd0};
      4'd8:    t = '{we: 1'b1, off: 5'd4,  dat: 32'd1};
      default: t = '{we: 1'b1, off: 5'd4,  dat: 32'd0};
    endcase
    return t;
  endfunction

  state_t      state;
  logic [3:0]  txn_q;      // index of the transaction in flight or next to issue
  logic [7:0]  to_cnt;
  logic [15:0] wait_cnt;
  logic [9:0]  loc_q, adj_q;
  logic        lm_q, am_q, din_q;
  logic [15:0] settle_q;

  txn_t        nxt;
  logic        go_req;

  // Upper read-data bits carry nothing for this slave.
  logic        unused_dat_hi;
  assign unused_dat_hi = ^wbm_dat_i[31:16];

  // Decide whether a new request is launched this cycle, and what it is.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    go_req = 1'b0;
    nxt    = txn_lookup(txn_q, loc_q, adj_q, lm_q, am_q, din_q);
    case (state)
      ST_IDLE: begin
        go_req = start_i;
        nxt    = txn_lookup(4'd0, loc_max_clk_i, adj_max_clk_i,
                            loc_timer_m_i, adj_timer_m_i, data_in_i);
      end
      ST_GAP:  go_req = (txn_q != TXN_COUNT) && !((txn_q == TXN_READ) && (settle_q != 16'd0));
      ST_WAIT: go_req = (wait_cnt == 16'd0);
      default: go_req = 1'b0;
    endcase
  end

  // Sequencer FSM with registered bus and status outputs.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state     <= ST_IDLE;
      txn_q     <= '0;
      to_cnt    <= '0;
      wait_cnt  <= '0;
      loc_q     <= '0;
      adj_q     <= '0;
      lm_q      <= 1'b0;
      am_q      <= 1'b0;
      din_q     <= 1'b0;
      settle_q  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      result_o  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_req) begin
            busy_o   <= 1'b1;
            err_o    <= 1'b0;
            loc_q    <= loc_max_clk_i;
            adj_q    <= adj_max_clk_i;
            lm_q     <= loc_timer_m_i;
            am_q     <= adj_timer_m_i;
            din_q    <= data_in_i;
            settle_q <= settle_cycles_i;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wbm_ack_i || (to_cnt == TO_LAST)) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
          end
          if (wbm_ack_i) begin
            if (txn_q == TXN_READ) result_o <= wbm_dat_i[15:0];
            txn_q <= txn_q + 4'd1;
            state <= ST_GAP;
          end else if (to_cnt == TO_LAST) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= ST_FIN;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          // Ack is deliberately not looked at here: the slave may still show a stale one.
          if (go_req) begin
            state <= ST_REQ;
          end else if (txn_q == TXN_READ) begin
            wait_cnt <= settle_q - 16'd1;
            state    <= ST_WAIT;
          end else begin
            done_o <= 1'b1;
            state  <= ST_FIN;
          end
        end
        ST_WAIT: begin
          if (go_req) state <= ST_REQ;
          else        wait_cnt <= wait_cnt - 16'd1;
        end
        ST_FIN: begin
          busy_o <= 1'b0;
          txn_q  <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (go_req) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= nxt.we;
        wbm_sel_o <= nxt.we ? 4'hF : 4'h0;
        wbm_adr_o <= BASE_ADDR + {27'd0, nxt.off};
        wbm_dat_o <= nxt.dat;
        to_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_wb_sequencer.sv
// tb_pixel_wb_sequencer: scoreboard bench with a model pixel slave; expected
// transactions are queued at start and popped as the DUT's requests are acked.
module tb_pixel_wb_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 16;

  typedef struct {
    logic [9:0]  loc;
    logic [9:0]  adj;
    logic        lm;
    logic        am;
    logic        din;
    logic [15:0] settle;
  } cfg_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    int          cyc;
  } txn_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  loc_max_clk_i, adj_max_clk_i;
  logic        loc_timer_m_i, adj_timer_m_i, data_in_i;
  logic [15:0] settle_cycles_i;
  logic        busy_o, done_o, err_o;
  logic [15:0] result_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          clk_cnt  = 0;
  int          base     = 0;
  int          stb_cnt  = 0;
  txn_exp_t    exp_q[$];
  txn_exp_t    e_mon;

  logic        stale_mode = 1'b0;
  logic        drop_t3    = 1'b0;
  logic [15:0] rd_val     = 16'h0;
  logic        ack_q, stale_q;

  always #5 clk = ~clk;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  pixel_wb_sequencer #(.BASE_ADDR(BASE), .ACK_TIMEOUT(TO)) dut (
    .wb_clk_i        (clk),
    .wb_rst_ni       (rst_n),
    .start_i         (start_i),
    .loc_max_clk_i   (loc_max_clk_i),
    .adj_max_clk_i   (adj_max_clk_i),
    .loc_timer_m_i   (loc_timer_m_i),
    .adj_timer_m_i   (adj_timer_m_i),
    .data_in_i       (data_in_i),
    .settle_cycles_i (settle_cycles_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .result_o        (result_o),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_ack_i       (wbm_ack_i),
    .wbm_dat_i       (wbm_dat_i)
  );

  // Model pixel slave: registered ack one cycle after stb, optionally held an
  // extra cycle (stale), optionally never acking the adj_timer_m write.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      ack_q   <= wbm_stb_o && !ack_q && !(drop_t3 && (wbm_adr_o == BASE + 32'd12));
      stale_q <= ack_q;
    end
  end
  assign wbm_ack_i = ack_q | (stale_mode & stale_q);
  assign wbm_dat_i = (wbm_adr_o == BASE + 32'd28) ? {16'h5A5A, rd_val} : 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted request must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wbm_stb_o) stb_cnt++;
      if (wbm_stb_o && wbm_ack_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_txn_adr", wbm_adr_o, 32'h0);
        end else begin
          e_mon = exp_q.pop_front();
          check("adr", wbm_adr_o, e_mon.adr);
          check("we", {31'd0, wbm_we_o}, {31'd0, e_mon.we});
          check("sel", {28'd0, wbm_sel_o}, e_mon.we ? 32'hF : 32'h0);
          check("cyc_eq_stb", {31'd0, wbm_cyc_o}, 32'd1);
          if (e_mon.we) check("wdat", wbm_dat_o, e_mon.dat);
          check("ack_cycle", 32'(clk_cnt - base), 32'(e_mon.cyc));
        end
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check({pfx, "_ctl"}, {25'd0, busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o,
                          |wbm_sel_o}, 32'd0);
    check({pfx, "_result"}, {16'd0, result_o}, 32'd0);
    check({pfx, "_adr"}, wbm_adr_o, 32'd0);
    check({pfx, "_dat"}, wbm_dat_o, 32'd0);
  endtask

  // Called at a negedge: drive config, queue expected bus traffic, accept start.
  task automatic start_seq(input cfg_t c, input logic hold);
    int          offs [10];
    logic [31:0] dats [10];
    txn_exp_t    e;
    int          ntx;
    offs = '{20, 24, 8, 12, 16, 0, 0, 28, 4, 4};
    dats = '{32'(c.loc), 32'(c.adj), 32'(c.lm), 32'(c.am), 32'(c.din), 32'd1, 32'd0,
             32'd0, 32'd1, 32'd0};
    ntx  = drop_t3 ? 3 : 10;
    for (int j = 0; j < ntx; j++) begin
      e.adr = BASE + 32'(offs[j]);
      e.we  = (j != 7);
      e.dat = dats[j];
      e.cyc = (j < 7) ? 3 * j + 1 : 22 + int'(c.settle) + 3 * (j - 7);
      exp_q.push_back(e);
    end
    loc_max_clk_i   = c.loc;
    adj_max_clk_i   = c.adj;
    loc_timer_m_i   = c.lm;
    adj_timer_m_i   = c.am;
    data_in_i       = c.din;
    settle_cycles_i = c.settle;
    start_i         = 1'b1;
    stb_cnt         = 0;
    @(posedge clk);
    #1;
    base = clk_cnt;
    if (!hold) start_i = 1'b0;
    loc_max_clk_i   = 10'($urandom);
    adj_max_clk_i   = 10'($urandom);
    loc_timer_m_i   = 1'($urandom);
    adj_timer_m_i   = 1'($urandom);
    data_in_i       = 1'($urandom);
    settle_cycles_i = 16'($urandom_range(0, 40));
    @(negedge clk);
    check("busy_c0", {31'd0, busy_o}, 32'd1);
    check("err_c0", {31'd0, err_o}, 32'd0);
  endtask

  // Wait (bounded) for done, then check timing, status and scoreboard drain.
  task automatic finish_seq(input int exp_done, input logic exp_err,
                            input logic [15:0] exp_res, input int exp_stb);
    logic found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (done_o) found = 1'b1;
      else @(negedge clk);
    end
    if (!found) begin
      check("done_seen", 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    check("done_cycle", 32'(clk_cnt - base), 32'(exp_done));
    check("err", {31'd0, err_o}, {31'd0, exp_err});
    check("result", {16'd0, result_o}, {16'd0, exp_res});
    check("busy_fin", {31'd0, busy_o}, 32'd1);
    @(negedge clk);
    check("done_width", {31'd0, done_o}, 32'd0);
    check("busy_idle", {31'd0, busy_o}, 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    logic found;
    rst_n = 1'b0;
    start_i = 1'b0;
    loc_max_clk_i = '0; adj_max_clk_i = '0;
    loc_timer_m_i = 1'b0; adj_timer_m_i = 1'b0; data_in_i = 1'b0;
    settle_cycles_i = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal acquisition.
    rd_val = 16'hA5C3;
    c = '{loc: 10'd100, adj: 10'd37, lm: 1'b1, am: 1'b0, din: 1'b1, settle: 16'd5};
    start_seq(c, 1'b0);
    finish_seq(35, 1'b0, 16'hA5C3, 20);

    // Zero settle: read follows the T6 gap directly.
    rd_val = 16'h1234;
    c = '{loc: 10'h3FF, adj: 10'd1, lm: 1'b0, am: 1'b1, din: 1'b0, settle: 16'd0};
    start_seq(c, 1'b0);
    finish_seq(30, 1'b0, 16'h1234, 20);

    // Stale ack held into the gap cycle.
    stale_mode = 1'b1;
    rd_val = 16'hA5C3;
    c = '{loc: 10'd100, adj: 10'd37, lm: 1'b1, am: 1'b0, din: 1'b1, settle: 16'd5};
    start_seq(c, 1'b0);
    finish_seq(35, 1'b0, 16'hA5C3, 20);
    stale_mode = 1'b0;

    // Timeout on T3: result keeps its previous value, err sticks.
    drop_t3 = 1'b1;
    rd_val = 16'h7777;
    c = '{loc: 10'd55, adj: 10'd66, lm: 1'b0, am: 1'b0, din: 1'b1, settle: 16'd7};
    start_seq(c, 1'b0);
    finish_seq(9 + TO, 1'b1, 16'hA5C3, 6 + TO);
    @(negedge clk);
    check("err_sticky", {31'd0, err_o}, 32'd1);
    drop_t3 = 1'b0;

    // Good start after timeout clears err.
    rd_val = 16'h0F0F;
    c = '{loc: 10'd1, adj: 10'd2, lm: 1'b1, am: 1'b1, din: 1'b0, settle: 16'd2};
    start_seq(c, 1'b0);
    finish_seq(32, 1'b0, 16'h0F0F, 20);

    // Start held high: exactly one sequence, next accepted from IDLE at 31+S.
    rd_val = 16'hC0DE;
    c = '{loc: 10'd512, adj: 10'd3, lm: 1'b0, am: 1'b1, din: 1'b1, settle: 16'd3};
    start_seq(c, 1'b1);
    finish_seq(33, 1'b0, 16'hC0DE, 20);
    rd_val = 16'h4242;
    c = '{loc: 10'd7, adj: 10'd900, lm: 1'b1, am: 1'b0, din: 1'b0, settle: 16'd1};
    start_seq(c, 1'b0);
    finish_seq(31, 1'b0, 16'h4242, 20);

    // Reset during T7 request.
    rd_val = 16'h9999;
    c = '{loc: 10'd20, adj: 10'd21, lm: 1'b1, am: 1'b1, din: 1'b1, settle: 16'd4};
    start_seq(c, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (wbm_stb_o && (wbm_adr_o == BASE + 32'd28)) found = 1'b1;
      else @(negedge clk);
    end
    check("t7_req_seen", {31'd0, found}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stb_cnt = 0;
    repeat (10) @(negedge clk);
    check("idle_after_rst_stb", 32'(stb_cnt), 32'd0);
    check("idle_after_rst_busy", {31'd0, busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
